// File: rtl/flag_branch_unit.sv
// -----------------------------------------------------------------------------
// flag_branch_unit
//
// Purpose:
//   Consumer side of the ALU condition-code interface. Holds the architectural
//   flag register (Z, V, N), updating it from EX results according to the
//   opcode's write class. Resolves B/BR branches against those flags. A taken
//   branch produces a one-cycle registered redirect and a flush that stays
//   high for FLUSH_CYCLES cycles.
//
// Configuration macro:
//   FLAG_FWD_EN  When defined, a branch presented in the same IDLE cycle as a
//                flag-writing ALU result is evaluated on the merged new flags
//                without stalling. When undefined, that case stalls the branch
//                for one cycle so it is evaluated on the updated flags_q.
//
// Parameters:
//   FLUSH_CYCLES  number of cycles flush is high after a taken branch (1..7)
//
// Ports:
//   clk          core clock, rising edge
//   rst          asynchronous active-high reset
//   alu_valid    ALU result in EX is real this cycle
//   alu_opcode   ALU opcode of that result
//   alu_flags    ALU flags [2]=Z [1]=V [0]=N
//   br_req       branch presented for resolution
//   br_ccc       branch condition code
//   br_target    precomputed branch target
//   br_stall     request not accepted this cycle (combinational)
//   br_done      one-cycle pulse, accepted branch resolved not-taken
//   redirect     one-cycle pulse, taken branch
//   redirect_pc  branch target, valid while redirect=1, holds otherwise
//   flush        squash younger instructions
//   flags_q      current flag register
// -----------------------------------------------------------------------------
module flag_branch_unit #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [2:0]  alu_opcode,
  input  logic [2:0]  alu_flags,
  input  logic        br_req,
  input  logic [2:0]  br_ccc,
  input  logic [15:0] br_target,
  output logic        br_stall,
  output logic        br_done,
  output logic        redirect,
  output logic [15:0] redirect_pc,
  output logic        flush,
  output logic [2:0]  flags_q
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REDIR = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [2:0]  flags_reg, flags_next;
  logic        br_done_reg, br_done_next;
  logic        redirect_reg, redirect_next;
  logic        flush_reg, flush_next;
  logic [15:0] redirect_pc_reg;

  logic        wr_all;     // ADD/SUB: Z, V and N are written
  logic        wr_z;       // XOR/SLL/SRA/ROR: only Z is written
  logic        flag_wr;
  logic [2:0]  flags_merged;
  logic [2:0]  eval_flags;
  logic        hazard;
  logic        accept;
  logic        taken;

  // Branch condition evaluation on a Z/V/N triple.
  function automatic logic cond_met(input logic [2:0] ccc, input logic [2:0] f);
    logic z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (ccc)
      3'b000:  cond_met = !z;                  // NEQ
      3'b001:  cond_met = z;                   // EQ
      3'b010:  cond_met = !z && !n;            // GT
      3'b011:  cond_met = n;                   // LT
      3'b100:  cond_met = z || (!z && !n);     // GTE
      3'b101:  cond_met = n || z;              // LTE
      3'b110:  cond_met = v;                   // OVFL
      default: cond_met = 1'b1;                // always
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Flag write path
  // ---------------------------------------------------------------------------
  assign wr_all = (alu_opcode == 3'b000) || (alu_opcode == 3'b001);
  assign wr_z   = (alu_opcode == 3'b010) || (alu_opcode == 3'b100) ||
                  (alu_opcode == 3'b101) || (alu_opcode == 3'b110);

  // Results arriving under flush belong to squashed instructions.
  assign flag_wr = alu_valid && !flush_reg && (wr_all || wr_z);

  assign flags_merged = {(wr_all || wr_z) ? alu_flags[2]   : flags_reg[2],
                         wr_all           ? alu_flags[1:0] : flags_reg[1:0]};

  assign flags_next = flag_wr ? flags_merged : flags_reg;

  // ---------------------------------------------------------------------------
  // Branch acceptance and evaluation
  // ---------------------------------------------------------------------------
`ifdef FLAG_FWD_EN
  // Same-cycle flag write is forwarded into the evaluation; no hazard stall.
  assign hazard     = 1'b0;
  assign eval_flags = flag_wr ? flags_merged : flags_reg;
`else
  // Same-cycle flag write holds the branch one cycle so it sees flags_q.
  assign hazard     = flag_wr && br_req;
  assign eval_flags = flags_reg;
`endif

  assign br_stall = (state_reg != ST_IDLE) || hazard;
  assign accept   = br_req && !br_stall;
  assign taken    = accept && cond_met(br_ccc, eval_flags);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and next values of the registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    br_done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (taken) begin
          state_next = ST_REDIR;
        end
        br_done_next = accept && !taken;
      end
      ST_REDIR: begin
        if (FLUSH_CYCLES <= 1) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_FLUSH;
          cnt_next   = FLUSH_RELOAD;
        end
      end
      ST_FLUSH: begin
        if (cnt_reg <= 3'd1) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    // Outputs are registered copies of what the next state implies, so they
    // line up exactly with the state they describe.
    redirect_next = (state_next == ST_REDIR);
    flush_next    = (state_next != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and flag register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_reg       <= 3'b000;
      br_done_reg     <= 1'b0;
      redirect_reg    <= 1'b0;
      flush_reg       <= 1'b0;
      redirect_pc_reg <= 16'h0000;
    end else begin
      flags_reg    <= flags_next;
      br_done_reg  <= br_done_next;
      redirect_reg <= redirect_next;
      flush_reg    <= flush_next;
      // Target is captured at acceptance and held until the next taken branch.
      if (taken) begin
        redirect_pc_reg <= br_target;
      end
    end
  end

  assign br_done     = br_done_reg;
  assign redirect    = redirect_reg;
  assign redirect_pc = redirect_pc_reg;
  assign flush       = flush_reg;
  assign flags_q     = flags_reg;

endmodule
